// File: rtl/account_arbiter.sv
// rtl/account_arbiter.sv - two-requester round-robin arbiter serialising transactions on an account balance table
// Optional feature: define ARB_TXN_COUNT_EN to add the saturating txn_count output.
module account_arbiter #(
    parameter int          NUM_ACCOUNTS = 10,
    parameter logic [15:0] INIT_BALANCE = 16'd500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [3:0]  op,
    input  logic [7:0]  acc,
    input  logic [31:0] amt,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  status,
    output logic [15:0] balance_out,
`ifdef ARB_TXN_COUNT_EN
    output logic [15:0] txn_count,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;

    localparam logic [1:0] OP_WITHDRAW = 2'd1;
    localparam logic [1:0] OP_DEPOSIT  = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;
    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_INSUFF   = 2'd1;
    localparam logic [1:0] ST_OVF      = 2'd2;
    localparam logic [1:0] ST_BAD      = 2'd3;

    state_t      state, state_nxt;
    logic        prio;          // requester that wins when both ask at once
    logic        win;
    logic [1:0]  op_q;
    logic [3:0]  acc_q;
    logic [15:0] amt_q;
    logic [15:0] mem [NUM_ACCOUNTS];
    logic [15:0] rd_bal;
    logic        acc_ok;
    logic [16:0] sum;
    logic [1:0]  res_status;
    logic [15:0] res_bal;
    logic        res_we;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: only IDLE waits, the rest of the sequence is fixed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = GRANT;
            GRANT:   state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: done mirrors the held grant during the single RESP cycle
    always_comb begin
        busy = (state != IDLE);
        done = (state == RESP) ? grant : 2'b00;
    end

    // Round-robin pick: a lone requester wins, a tie goes to the favoured one
    always_comb begin
        if (req == 2'b11) win = prio;
        else              win = req[1];
    end

    // Capture the winner's request so later input changes cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant <= 2'b00;
            prio  <= 1'b0;
            op_q  <= 2'd0;
            acc_q <= 4'd0;
            amt_q <= 16'd0;
        end else if (state == IDLE && |req) begin
            grant <= win ? 2'b10 : 2'b01;
            prio  <= ~win;
            op_q  <= win ? op[3:2]    : op[1:0];
            acc_q <= win ? acc[7:4]   : acc[3:0];
            amt_q <= win ? amt[31:16] : amt[15:0];
        end else if (state == RESP) begin
            grant <= 2'b00;
        end
    end

    // Read the entry and evaluate the operation (used during EXEC)
    always_comb begin
        acc_ok = (32'(acc_q) < NUM_ACCOUNTS);
        rd_bal = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (32'(acc_q) == i) rd_bal = mem[i];
        end
        sum        = {1'b0, rd_bal} + {1'b0, amt_q};
        res_status = ST_OK;
        res_bal    = rd_bal;
        res_we     = 1'b0;
        if (!acc_ok || op_q == OP_RSVD) begin
            res_status = ST_BAD;
            res_bal    = '0;
        end else begin
            case (op_q)
                OP_WITHDRAW: begin
                    if (amt_q > rd_bal) begin
                        res_status = ST_INSUFF;
                    end else begin
                        res_bal = rd_bal - amt_q;
                        res_we  = 1'b1;
                    end
                end
                OP_DEPOSIT: begin
                    if (sum[16]) begin
                        res_status = ST_OVF;
                    end else begin
                        res_bal = sum[15:0];
                        res_we  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Balance table: reload on reset, commit successful updates leaving EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) mem[i] <= INIT_BALANCE;
        end else if (state == EXEC && res_we) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                if (32'(acc_q) == i) mem[i] <= res_bal;
            end
        end
    end

    // Response registers, loaded so they are valid alongside done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status      <= ST_OK;
            balance_out <= '0;
        end else if (state == EXEC) begin
            status      <= res_status;
            balance_out <= res_bal;
        end
    end

`ifdef ARB_TXN_COUNT_EN
    // Count successful completions, holding at the top value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txn_count <= '0;
        end else if (state == RESP && status == ST_OK && txn_count != 16'hFFFF) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_account_arbiter.sv
// tb/tb_account_arbiter.sv - randomized self-checking bench for account_arbiter with a behavioural account model
module tb_account_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [3:0]  op  = 4'd0;
    logic [7:0]  acc = 8'd0;
    logic [31:0] amt = 32'd0;
    logic [1:0]  grant, done, status;
    logic [15:0] balance_out;
    logic        busy;
`ifdef ARB_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    int checks   = 0;
    int failures = 0;
    int bal_m [10];
    int prio_m;

    account_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .acc(acc), .amt(amt),
        .grant(grant), .done(done), .status(status), .balance_out(balance_out),
`ifdef ARB_TXN_COUNT_EN
        .txn_count(txn_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) bal_m[i] = 500;
        prio_m = 0;
    endfunction

    function automatic void model_txn(input int o, input int a, input int m, output int st, output int bo);
        if (a >= 10 || o == 3) begin
            st = 3; bo = 0;
        end else if (o == 0) begin
            st = 0; bo = bal_m[a];
        end else if (o == 1) begin
            if (m > bal_m[a]) begin st = 1; bo = bal_m[a]; end
            else begin bal_m[a] = bal_m[a] - m; st = 0; bo = bal_m[a]; end
        end else begin
            if (bal_m[a] + m > 65535) begin st = 2; bo = bal_m[a]; end
            else begin bal_m[a] = bal_m[a] + m; st = 0; bo = bal_m[a]; end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Starts at a falling edge with the DUT idle; returns observations, ends idle at a falling edge
    task automatic issue(input logic [1:0] rq, input logic [3:0] o, input logic [7:0] a, input logic [31:0] m,
                         output int lat, output logic [1:0] gr, output logic [1:0] dn, output logic [1:0] st,
                         output logic [15:0] bo, output logic [1:0] dn_after);
        req = rq; op = o; acc = a; amt = m;
        @(negedge clk);
        lat = 1; gr = grant;
        req = 2'b00; op = 4'($urandom); acc = 8'($urandom); amt = $urandom;
        while (done == 2'b00 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        dn = done; st = status; bo = balance_out;
        @(negedge clk);
        dn_after = done;
    endtask

    task automatic test_reset();
        int lat; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        #2 rst = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (status !== 2'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", status); end
        checks++; if (balance_out !== 16'd0) begin failures++; $display("FAIL reset_balance got=%0d exp=0", balance_out); end
`ifdef ARB_TXN_COUNT_EN
        checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL reset_txn_count got=%0d exp=0", txn_count); end
`endif
        @(negedge clk);
        rst = 1'b1;
        issue(2'b01, 4'b0011, 8'h00, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd3) begin failures++; $display("FAIL rsvd_op_status got=%0d exp=3", st); end
        req = 2'b01; op = 4'd0; acc = 8'd0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL grant_state got busy=%b grant=%b exp busy=1 grant=01", busy, grant); end
        #2 rst = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL async_reset_ctrl got grant=%b busy=%b done=%b exp 00/0/00", grant, busy, done); end
        checks++; if (status !== 2'd0 || balance_out !== 16'd0) begin failures++; $display("FAIL async_reset_resp got status=%0d bal=%0d exp 0/0", status, balance_out); end
        @(negedge clk);
        req = 2'b00; rst = 1'b1;
        model_reset();
    endtask

    task automatic test_balance();
        int lat; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        do_reset();
        issue(2'b01, 4'b0000, 8'h03, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (lat !== 3) begin failures++; $display("FAIL balance_latency got=%0d exp=3", lat); end
        checks++; if (gr !== 2'b01) begin failures++; $display("FAIL balance_grant got=%b exp=01", gr); end
        checks++; if (dn !== 2'b01) begin failures++; $display("FAIL balance_done got=%b exp=01", dn); end
        checks++; if (st !== 2'd0 || bo !== 16'd500) begin failures++; $display("FAIL balance_result got st=%0d bal=%0d exp 0/500", st, bo); end
        checks++; if (da !== 2'b00) begin failures++; $display("FAIL done_one_cycle got=%b exp=00", da); end
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_resp got grant=%b busy=%b exp 00/0", grant, busy); end
    endtask

    task automatic test_withdraw();
        int lat; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        issue(2'b10, 4'b0100, 8'h20, {16'd200, 16'd0}, lat, gr, dn, st, bo, da);
        checks++; if (gr !== 2'b10 || dn !== 2'b10) begin failures++; $display("FAIL withdraw1_owner got grant=%b done=%b exp 10/10", gr, dn); end
        checks++; if (st !== 2'd0 || bo !== 16'd300) begin failures++; $display("FAIL withdraw1_result got st=%0d bal=%0d exp 0/300", st, bo); end
        issue(2'b10, 4'b0100, 8'h20, {16'd400, 16'd0}, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd1 || bo !== 16'd300) begin failures++; $display("FAIL withdraw2_result got st=%0d bal=%0d exp 1/300", st, bo); end
        issue(2'b10, 4'b0100, 8'h20, {16'd300, 16'd0}, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd0 || bo !== 16'd0) begin failures++; $display("FAIL withdraw_exact got st=%0d bal=%0d exp 0/0", st, bo); end
    endtask

    task automatic test_back_to_back();
        int lat; int n; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        logic [1:0] exp_g [3];
        exp_g = '{2'b01, 2'b10, 2'b01};
        do_reset();
        req = 2'b11; op = 4'b1010; acc = 8'h00; amt = {16'd10, 16'd10};
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done == 2'b00 && n < 10);
            checks++; if (done !== exp_g[k]) begin failures++; $display("FAIL rr_done_%0d got=%b exp=%b", k, done, exp_g[k]); end
            checks++; if (n !== (k == 0 ? 3 : 4)) begin failures++; $display("FAIL rr_spacing_%0d got=%0d exp=%0d", k, n, (k == 0 ? 3 : 4)); end
        end
        req = 2'b00;
        @(negedge clk);
        issue(2'b01, 4'b0000, 8'h00, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd0 || bo !== 16'd530) begin failures++; $display("FAIL rr_final_balance got st=%0d bal=%0d exp 0/530", st, bo); end
    endtask

    task automatic test_overflow_bad();
        int lat; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        do_reset();
        issue(2'b01, 4'b0010, 8'h05, {16'd0, 16'd65100}, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd2 || bo !== 16'd500) begin failures++; $display("FAIL overflow_result got st=%0d bal=%0d exp 2/500", st, bo); end
        issue(2'b01, 4'b0000, 8'h05, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (bo !== 16'd500) begin failures++; $display("FAIL overflow_no_write got=%0d exp=500", bo); end
        issue(2'b01, 4'b0010, 8'h05, {16'd0, 16'd65035}, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd0 || bo !== 16'd65535) begin failures++; $display("FAIL deposit_to_max got st=%0d bal=%0d exp 0/65535", st, bo); end
        issue(2'b01, 4'b0001, 8'h05, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd0 || bo !== 16'd65535) begin failures++; $display("FAIL zero_amount got st=%0d bal=%0d exp 0/65535", st, bo); end
        issue(2'b10, 4'b1000, 8'hC0, {16'd5, 16'd0}, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd3 || bo !== 16'd0 || dn !== 2'b10) begin failures++; $display("FAIL bad_account got st=%0d bal=%0d done=%b exp 3/0/10", st, bo, dn); end
        issue(2'b01, 4'b0000, 8'h0A, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (st !== 2'd3 || bo !== 16'd0) begin failures++; $display("FAIL acc_equal_num got st=%0d bal=%0d exp 3/0", st, bo); end
    endtask

    task automatic test_reset_abort();
        int lat; int seen; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        do_reset();
        req = 2'b01; op = 4'b0001; acc = 8'h01; amt = 32'd100;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || grant !== 2'b00) begin failures++; $display("FAIL abort_reset_state got busy=%b grant=%b exp 0/00", busy, grant); end
        seen = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== 2'b00) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d cycles exp=0", seen); end
        issue(2'b01, 4'b0000, 8'h01, 32'd0, lat, gr, dn, st, bo, da);
        checks++; if (bo !== 16'd500) begin failures++; $display("FAIL abort_balance got=%0d exp=500", bo); end
    endtask

    task automatic test_random();
        int lat; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        logic [1:0] rq; logic [3:0] o; logic [7:0] a; logic [31:0] m;
        int w, ow, aw, mw, est, ebo, mlo, mhi;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            rq  = 2'($urandom_range(1, 3));
            o   = 4'($urandom);
            a   = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            mlo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 600)) : int'($urandom_range(60000, 65535));
            mhi = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 600)) : int'($urandom_range(60000, 65535));
            m   = {16'(mhi), 16'(mlo)};
            w   = (rq == 2'b11) ? prio_m : ((rq == 2'b10) ? 1 : 0);
            prio_m = 1 - w;
            ow  = (w == 1) ? int'(o[3:2]) : int'(o[1:0]);
            aw  = (w == 1) ? int'(a[7:4]) : int'(a[3:0]);
            mw  = (w == 1) ? mhi : mlo;
            model_txn(ow, aw, mw, est, ebo);
            issue(rq, o, a, m, lat, gr, dn, st, bo, da);
            checks++;
            if (lat !== 3 || gr !== 2'(1 << w) || dn !== 2'(1 << w) || st !== 2'(est) || bo !== 16'(ebo)) begin
                failures++;
                $display("FAIL random_%0d got lat=%0d grant=%b done=%b st=%0d bal=%0d exp lat=3 grant=%b st=%0d bal=%0d",
                         i, lat, gr, dn, st, bo, 2'(1 << w), est, ebo);
            end
        end
    endtask

    task automatic test_txn_count();
`ifdef ARB_TXN_COUNT_EN
        int lat; logic [1:0] gr, dn, st, da; logic [15:0] bo;
        do_reset();
        issue(2'b01, 4'b0000, 8'h00, 32'd0, lat, gr, dn, st, bo, da);
        issue(2'b01, 4'b0010, 8'h00, 32'd1, lat, gr, dn, st, bo, da);
        issue(2'b10, 4'b0100, 8'h00, {16'd1, 16'd0}, lat, gr, dn, st, bo, da);
        issue(2'b01, 4'b0001, 8'h00, 32'd60000, lat, gr, dn, st, bo, da);
        checks++; if (txn_count !== 16'd3) begin failures++; $display("FAIL txn_count got=%0d exp=3", txn_count); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_balance();
        test_withdraw();
        test_back_to_back();
        test_overflow_bad();
        test_reset_abort();
        test_random();
        test_txn_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/account_arbiter.md
ACCOUNT_ARBITER -- requirements
Module: account_arbiter

Interface
REQ-001 The block SHALL provide parameter NUM_ACCOUNTS, default 10, number of account balance entries.
REQ-002 The block SHALL provide parameter INIT_BALANCE, default 16'd500, balance loaded into every entry on reset.
REQ-003 The block SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL provide port req  input  2  per-requester transaction request; bit i belongs to requester i.
REQ-006 The block SHALL provide port op  input  4  per-requester operation, 2 bits each ({op1,op0}): 0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 reserved.
REQ-007 The block SHALL provide port acc  input  8  per-requester account index, 4 bits each.
REQ-008 The block SHALL provide port amt  input  32  per-requester amount, 16 bits each, unsigned.
REQ-009 The block SHALL provide port grant  output  2  one-hot owner of the current transaction.
REQ-010 The block SHALL provide port done  output  2  one-cycle completion pulse for the owning requester.
REQ-011 The block SHALL provide port status  output  2  result: 0 OK, 1 INSUFFICIENT, 2 OVERFLOW, 3 BAD_ACCOUNT.
REQ-012 The block SHALL provide port balance_out  output  16  account balance after the transaction.
REQ-013 The block SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT, EXEC, RESP.
REQ-015 In IDLE with any req bit high, the FSM SHALL go to GRANT next cycle; otherwise it stays in IDLE.
REQ-016 On the IDLE->GRANT edge the arbiter SHALL pick one requester round-robin, latch its op/acc/amt, and assert grant one-hot.
REQ-017 Round-robin: when both request, the requester not served last SHALL win; after reset requester 0 has priority.
REQ-018 GRANT->EXEC SHALL be unconditional; EXEC reads the entry and computes the result.
REQ-019 EXEC->RESP SHALL be unconditional; the balance write commits on this edge, only when status is OK and op is WITHDRAW or DEPOSIT.
REQ-020 In RESP, done[owner] SHALL be high for exactly one cycle, with status and balance_out valid in that same cycle; RESP->IDLE follows.
REQ-021 Latency: done SHALL assert exactly 3 cycles after the cycle in which req was sampled in IDLE.
REQ-022 grant SHALL stay constant from GRANT through RESP and be 0 in IDLE.
REQ-023 Requester inputs changing or req dropping after the grant SHALL NOT affect the transaction in flight.
REQ-024 A requester whose req is still high in the cycle after RESP SHALL be treated as a new request.
REQ-025 acc >= NUM_ACCOUNTS or op == 3 SHALL give status BAD_ACCOUNT, no write, and balance_out 0.
REQ-026 WITHDRAW with amt > balance SHALL give INSUFFICIENT, no write, and balance_out equal to the unchanged balance.
REQ-027 DEPOSIT where balance + amt > 65535, computed 17-bit, SHALL give OVERFLOW, no write, and balance_out equal to the unchanged balance.
REQ-028 amt 0 SHALL be legal: OK status, balance unchanged.
REQ-029 BALANCE SHALL give OK and the current balance, with no write.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, grant 0, done 0, status 0, balance_out 0, busy 0, and the round-robin pointer to favour requester 0.
REQ-031 Reset SHALL load INIT_BALANCE into every entry.
REQ-032 Reset during GRANT/EXEC SHALL abort the transaction with no partial write and no done pulse.

Configuration
REQ-033 Macro ARB_TXN_COUNT_EN defined: the block SHALL add output txn_count (16 bits, reset 0) that increments on each done with status OK and saturates at 65535.
REQ-034 ARB_TXN_COUNT_EN undefined: the txn_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, then requester 0 BALANCE acc 3 -> done[0] 3 cycles later, status 0, balance_out 500.
REQ-036 Requester 1 WITHDRAW acc 2 amt 200, then WITHDRAW amt 400 -> first OK, balance 300; second INSUFFICIENT, balance 300.
REQ-037 Both req high continuously, DEPOSIT 10 to acc 0 -> grants alternate 01,10,01; acc 0 reads 530 after 3 done pulses.
REQ-038 DEPOSIT 65100 to acc 5 (balance 500) -> OVERFLOW, balance stays 500; acc 12 -> BAD_ACCOUNT, balance_out 0.
REQ-039 Assert rst while in EXEC of WITHDRAW 100 acc 1 -> no done; acc 1 reads 500 after release.
REQ-040 With ARB_TXN_COUNT_EN defined, 3 OK transactions and 1 INSUFFICIENT -> txn_count = 3.
